// File: rtl/axis_serial_div.sv
// 32-bit radix-2 restoring divider; result pulses on m_axis_dout 33 cycles after the operand handshake.
// Both operand channels accept only in IDLE, together; the result channel has no backpressure.
module axis_serial_div #(
    parameter int SIGNED = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    output logic [63:0] m_axis_dout_tdata,
    output logic        m_axis_dout_tvalid
);

    localparam bit SGN = (SIGNED != 0);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic        start;
    logic [31:0] a_sh, b_mag, q, rem, a_raw;
    logic [4:0]  cnt;
    logic        neg_q, neg_r, b_zero;
    logic [31:0] a_in_mag, b_in_mag;
    logic [32:0] rem_sh, diff;
    logic        take;
    logic [31:0] rem_nxt, q_nxt, q_fin, r_fin;
    logic [63:0] res;

    assign start = (state == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

    assign a_in_mag = (SGN && s_axis_dividend_tdata[31]) ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    assign b_in_mag = (SGN && s_axis_divisor_tdata[31])  ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;

    // rem < divisor always holds, so a borrow-free difference fits back in 32 bits
    assign rem_sh  = {rem, a_sh[31]};
    assign diff    = rem_sh - {1'b0, b_mag};
    assign take    = !diff[32];
    assign rem_nxt = take ? diff[31:0] : rem_sh[31:0];
    assign q_nxt   = {q[30:0], take};

    assign q_fin = neg_q ? -q_nxt : q_nxt;
    assign r_fin = neg_r ? -rem_nxt : rem_nxt;
    // Divide by zero bypasses sign fix-up: all-ones quotient, raw dividend as remainder
    assign res   = b_zero ? {32'hFFFF_FFFF, a_raw} : {q_fin, r_fin};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axis_dividend_tready = (state == IDLE) && !reset;
        s_axis_divisor_tready  = (state == IDLE) && !reset;
        m_axis_dout_tvalid     = (state == DONE) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh              <= '0;
            b_mag             <= '0;
            q                 <= '0;
            rem               <= '0;
            a_raw             <= '0;
            cnt               <= '0;
            neg_q             <= 1'b0;
            neg_r             <= 1'b0;
            b_zero            <= 1'b0;
            m_axis_dout_tdata <= '0;
        end else if (start) begin
            a_sh   <= a_in_mag;
            b_mag  <= b_in_mag;
            a_raw  <= s_axis_dividend_tdata;
            q      <= '0;
            rem    <= '0;
            cnt    <= '0;
            neg_q  <= SGN && (s_axis_dividend_tdata[31] ^ s_axis_divisor_tdata[31]);
            neg_r  <= SGN && s_axis_dividend_tdata[31];
            b_zero <= (s_axis_divisor_tdata == 32'd0);
        end else if (state == CALC) begin
            a_sh <= {a_sh[30:0], 1'b0};
            rem  <= rem_nxt;
            q    <= q_nxt;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd31) begin
                m_axis_dout_tdata <= res;
            end
        end
    end

endmodule

// File: tb/tb_axis_serial_div.sv
// Directed and randomized checks of both divider flavours driven from shared operand channels.
module tb_axis_serial_div;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dvd_dat = '0, dvs_dat = '0;
    logic        dvd_vld = 1'b0, dvs_vld = 1'b0;
    logic        dvd_rdy_u, dvs_rdy_u, dvd_rdy_s, dvs_rdy_s;
    logic [63:0] dout_u, dout_s;
    logic        vld_u, vld_s;
    logic        rdy_all, rdy_any;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rdy_all = dvd_rdy_u & dvs_rdy_u & dvd_rdy_s & dvs_rdy_s;
    assign rdy_any = dvd_rdy_u | dvs_rdy_u | dvd_rdy_s | dvs_rdy_s;

    axis_serial_div #(.SIGNED(0)) dut_u (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tdata  (dvd_dat),
        .s_axis_dividend_tvalid (dvd_vld),
        .s_axis_dividend_tready (dvd_rdy_u),
        .s_axis_divisor_tdata   (dvs_dat),
        .s_axis_divisor_tvalid  (dvs_vld),
        .s_axis_divisor_tready  (dvs_rdy_u),
        .m_axis_dout_tdata      (dout_u),
        .m_axis_dout_tvalid     (vld_u)
    );

    axis_serial_div #(.SIGNED(1)) dut_s (
        .clk                    (clk),
        .reset                  (reset),
        .s_axis_dividend_tdata  (dvd_dat),
        .s_axis_dividend_tvalid (dvd_vld),
        .s_axis_dividend_tready (dvd_rdy_s),
        .s_axis_divisor_tdata   (dvs_dat),
        .s_axis_divisor_tvalid  (dvs_vld),
        .s_axis_divisor_tready  (dvs_rdy_s),
        .m_axis_dout_tdata      (dout_s),
        .m_axis_dout_tvalid     (vld_s)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_u(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        return {a / b, a % b};
    endfunction

    function automatic logic [63:0] ref_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        return {sq, sr};
    endfunction

    // Presents both operands in cycle T, then walks T+1..T+34 checking ready, valid, hold and result.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] eu, input logic [63:0] es,
                           input bit hold, input string tag);
        logic [63:0] pu, ps, gu, gs;
        logic bad_rdy, bad_vld, bad_hold;
        pu = dout_u;
        ps = dout_s;
        gu = '0;
        gs = '0;
        bad_rdy = 1'b0;
        bad_vld = 1'b0;
        bad_hold = 1'b0;
        dvd_dat = a;
        dvs_dat = b;
        dvd_vld = 1'b1;
        dvs_vld = 1'b1;
        check({tag, "_rdy_idle"}, 64'(rdy_all), 64'd1);
        @(negedge clk);
        dvd_dat = ~a;
        dvs_dat = b ^ 32'h5A5A_5A5A;
        if (!hold) begin
            dvd_vld = 1'b0;
            dvs_vld = 1'b0;
        end
        for (int k = 1; k <= 33; k++) begin
            if (k > 1) @(negedge clk);
            if (rdy_any) bad_rdy = 1'b1;
            if (k < 33) begin
                if (vld_u || vld_s) bad_vld = 1'b1;
                if (dout_u !== pu || dout_s !== ps) bad_hold = 1'b1;
            end else begin
                if (!(vld_u && vld_s)) bad_vld = 1'b1;
                gu = dout_u;
                gs = dout_s;
            end
        end
        dvd_vld = 1'b0;
        dvs_vld = 1'b0;
        @(negedge clk);
        check({tag, "_ctl_rdy_vld_hold"}, 64'({bad_rdy, bad_vld, bad_hold}), 64'd0);
        check({tag, "_unsigned"}, gu, eu);
        check({tag, "_signed"}, gs, es);
        check({tag, "_after_rdy_vld_hold"},
              64'({rdy_all, vld_u, vld_s, (dout_u === gu) && (dout_s === gs)}), 64'b1001);
    endtask

    initial begin
        logic [31:0] a, b;
        logic bad;

        @(negedge clk);
        check("reset_ctl", 64'({rdy_any, vld_u, vld_s}), 64'd0);
        check("reset_dout_u", dout_u, 64'd0);
        check("reset_dout_s", dout_s, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'({rdy_all, vld_u, vld_s}), 64'b100);

        run_div(32'd100, 32'd7, 64'h0000000E_00000002, 64'h0000000E_00000002, 1'b0, "div_100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 64'h7FFFFFFC_00000001, 64'hFFFFFFFD_FFFFFFFF, 1'b0, "div_m7_2");
        run_div(32'd7, 32'hFFFF_FFFE, 64'h00000000_00000007, 64'hFFFFFFFD_00000001, 1'b0, "div_7_m2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 64'h80000000_00000000, 1'b0, "div_ovf");
        run_div(32'h1234_5678, 32'd0, 64'hFFFFFFFF_12345678, 64'hFFFFFFFF_12345678, 1'b0, "div0_pos");
        run_div(32'hFFFF_FFFB, 32'd0, 64'hFFFFFFFF_FFFFFFFB, 64'hFFFFFFFF_FFFFFFFB, 1'b0, "div0_m5");
        run_div(32'hFFFF_FFFF, 32'h10, 64'h0FFFFFFF_0000000F, 64'h00000000_FFFFFFFF, 1'b1, "div_hold");

        // dividend alone must not start anything
        dvd_dat = 32'd6;
        dvd_vld = 1'b1;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!rdy_all || vld_u || vld_s) bad = 1'b1;
        end
        check("dividend_alone", 64'(bad), 64'd0);
        run_div(32'd6, 32'd3, 64'h00000002_00000000, 64'h00000002_00000000, 1'b0, "div_6_3");

        // reset in the middle of a division discards it
        dvd_dat = 32'd1000;
        dvs_dat = 32'd3;
        dvd_vld = 1'b1;
        dvs_vld = 1'b1;
        @(negedge clk);
        dvd_vld = 1'b0;
        dvs_vld = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_ctl", 64'({rdy_any, vld_u, vld_s}), 64'd0);
        check("midreset_dout", {dout_u[31:0], dout_s[31:0]}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_idle", 64'({rdy_all, vld_u, vld_s}), 64'b100);
        check("midreset_dout_u", dout_u, 64'd0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (vld_u || vld_s || dout_u !== 64'd0 || dout_s !== 64'd0) bad = 1'b1;
        end
        check("midreset_no_pulse", 64'(bad), 64'd0);
        run_div(32'd9, 32'd4, 64'h00000002_00000001, 64'h00000002_00000001, 1'b0, "div_9_4");

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            case (i % 8)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                4: a = $urandom_range(0, 1000);
                default: ;
            endcase
            run_div(a, b, ref_u(a, b), ref_s(a, b), (i % 50) == 7, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
